stream_merge_buffer: RTL
========================

// Module: stream_merge_buffer
// PURPOSE
//  Consumer stage directly downstream of the dual-lane producer. Buffers lane 1 and lane 2
//  transactions (address, id) in per-lane FIFOs and merges them round-robin onto one
//  registered output port. Drives the per-lane stalls back to the producer and executes
//  per-lane flushes: the flushed id and every younger entry of that lane are squashed.
// PARAMETERS
//  ADDR_W   `ADDRESS_WIDTH  address width, all ports
//  ID_W     `ID_WIDTH       transaction id width, all ports
//  DEPTH    4               entries per lane FIFO, power of two, >=2
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high
//  in_address_1   in   ADDR_W  lane 1 address
//  in_id_1        in   ID_W    lane 1 id
//  in_valid_1     in   1       lane 1 beat present
//  out_stall_1    out  1       stall to lane 1 producer
//  flush_1        in   1       lane 1 flush strobe, 1 cycle
//  flush_id_1     in   ID_W    id to squash on lane 1
//  in_address_2 / in_id_2 / in_valid_2 / out_stall_2 / flush_2 / flush_id_2: as lane 1, lane 2
//  in_stall       in   1       downstream stall on merged output
//  out_address    out  ADDR_W  merged address
//  out_id         out  ID_W    merged id
//  out_valid      out  1       merged beat present
//  out_lane       out  1       0 = lane 1, 1 = lane 2
//  drop_count     out  8       saturating count of squashed transactions
// BEHAVIOUR
//  Reset: all FIFOs empty, out_valid/out_address/out_id/out_lane/drop_count = 0, stalls = 0,
//   RR pointer = lane 1. Reset mid-operation discards all buffered and output state.
//  Input handshake: beat accepted at edge when in_valid_N && !out_stall_N; source holds beat
//   while stalled. out_stall_N = (lane N count == DEPTH), from registered count; no same-cycle
//   pop bypass when full.
//  Output: register loads when empty (or squashed this cycle) or !in_stall; holds value while
//   out_valid && in_stall. Beat consumed at edge when out_valid && !in_stall.
//  Latency: beat accepted at edge E is visible on out_* after edge E+1 at earliest.
//  Arbitration: among lanes with non-empty head and not flush-blocked, round-robin; RR pointer
//   moves to the other lane after each grant. Single eligible lane is granted regardless of pointer.
//  Flush_N (evaluated on pre-edge state): search output reg (if lane N) then lane N FIFO head->tail
//   for id == flush_id_N.
//   - hit in output reg: output reg and whole lane N FIFO squashed.
//   - hit at FIFO index k: entries k..tail squashed (tail rewinds, count = k).
//   - any hit: lane N input beat of this cycle also dropped (not accepted, stall unaffected);
//     lane N excluded from arbitration this cycle.
//   - no hit, or input beat id == flush_id_N: only input beat dropped (counts as 1).
//   - no hit anywhere: no effect.
//  flush_1 and flush_2 same cycle: independent per lane; both may squash.
//  drop_count += number squashed this cycle (output reg + FIFO + input beat), saturates at 255.
//  FIFO pointers wrap modulo DEPTH; ids are compared as full ID_W, no lane decoding of id.
// TESTING
//  1 Reset, lane 1 streams ids 0x11..0x14, lane 2 idle, in_stall=0 -> out_id 0x11..0x14 in order, out_lane=0.
//  2 Both lanes stream, in_stall=0 -> out_id alternates 0x11,0x21,0x12,0x22...; no beat lost or duplicated.
//  3 in_stall=1 for 20 cycles -> out_* held; out_stall_1/2 rise once lane count hits DEPTH=4;
//    release -> all 8+1 beats emerge in RR order.
//  4 Lane 1 FIFO holds 0x13,0x14,0x15,0x16, in_stall=1, flush_1 id 0x14 -> count=1 (0x13 kept),
//    drop_count=3, lane 2 unaffected.
//  5 out_id=0x12 held by in_stall, FIFO 0x13,0x14, flush_1 id 0x12 -> out_valid=0 or lane-2 beat next edge,
//    lane 1 FIFO empty, drop_count=3.
//  6 Assert reset mid-stream with FIFOs non-empty -> all outputs 0 immediately; stream restarts cleanly.

Source files
------------

// File: rtl/stream_merge_buffer.sv
// Dual-lane buffered round-robin merge with per-lane id-based flush/squash.
// Each lane has a DEPTH-entry FIFO feeding one registered output port.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module stream_merge_buffer #(
  parameter int unsigned ADDR_W = `ADDRESS_WIDTH,
  parameter int unsigned ID_W   = `ID_WIDTH,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ID_W-1:0]   in_id_1,
  input  logic              in_valid_1,
  output logic              out_stall_1,
  input  logic              flush_1,
  input  logic [ID_W-1:0]   flush_id_1,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic [ID_W-1:0]   in_id_2,
  input  logic              in_valid_2,
  output logic              out_stall_2,
  input  logic              flush_2,
  input  logic [ID_W-1:0]   flush_id_2,
  input  logic              in_stall,
  output logic [ADDR_W-1:0] out_address,
  output logic [ID_W-1:0]   out_id,
  output logic              out_valid,
  output logic              out_lane,
  output logic [7:0]        drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RR_LANE1 = 1'b0, RR_LANE2 = 1'b1} rr_e;

  logic [ADDR_W-1:0] in_addr [2];
  logic [ID_W-1:0]   in_idv  [2];
  logic [ID_W-1:0]   fl_id   [2];
  logic              in_vld  [2];
  logic              fl      [2];

  logic [ADDR_W-1:0] mem_addr_q [2][DEPTH];
  logic [ID_W-1:0]   mem_id_q   [2][DEPTH];
  logic [PW-1:0]     head_q [2], head_d [2];
  logic [PW-1:0]     tail_q [2], tail_d [2];
  logic [CW-1:0]     cnt_q  [2], cnt_d  [2];

  logic              out_valid_q, out_valid_d;
  logic              out_lane_q, out_lane_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  rr_e               rr_q, rr_d;
  logic [7:0]        drop_q, drop_d;

  logic          stall    [2];
  logic          out_hit  [2];
  logic          fifo_hit [2];
  logic          hit      [2];
  logic [CW-1:0] k        [2];
  logic [CW-1:0] sq       [2];
  logic          in_drop  [2];
  logic          push     [2];
  logic          pop      [2];

  logic        elig1, elig2, load, any_gnt, gnt;
  logic [15:0] inc;
  logic [16:0] total;

  always_comb begin
    in_addr[0] = in_address_1;  in_addr[1] = in_address_2;
    in_idv[0]  = in_id_1;       in_idv[1]  = in_id_2;
    in_vld[0]  = in_valid_1;    in_vld[1]  = in_valid_2;
    fl[0]      = flush_1;       fl[1]      = flush_2;
    fl_id[0]   = flush_id_1;    fl_id[1]   = flush_id_2;
  end

  // Flush search order is oldest-first: output reg, then FIFO head..tail; first hit
  // defines the squash point and everything younger on that lane goes with it.
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      stall[n]    = (cnt_q[n] == FULL);
      out_hit[n]  = fl[n] && out_valid_q && (out_lane_q == 1'(n)) && (out_id_q == fl_id[n]);
      fifo_hit[n] = 1'b0;
      k[n]        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (fl[n] && !fifo_hit[n] && (CW'(i) < cnt_q[n]) &&
            (mem_id_q[n][head_q[n] + PW'(i)] == fl_id[n])) begin
          fifo_hit[n] = 1'b1;
          k[n]        = CW'(i);
        end
      end
      if (out_hit[n]) k[n] = '0;
      hit[n]     = out_hit[n] || fifo_hit[n];
      sq[n]      = hit[n] ? (cnt_q[n] - k[n]) : '0;
      in_drop[n] = fl[n] && in_vld[n] && !stall[n] && (hit[n] || (in_idv[n] == fl_id[n]));
      push[n]    = in_vld[n] && !stall[n] && !in_drop[n];
    end
  end

  always_comb begin
    elig1   = (cnt_q[0] != '0) && !hit[0];
    elig2   = (cnt_q[1] != '0) && !hit[1];
    load    = !out_valid_q || !in_stall || out_hit[0] || out_hit[1];
    any_gnt = elig1 || elig2;
    gnt     = (elig1 && elig2) ? (rr_q == RR_LANE2) : elig2;
    pop[0]  = load && any_gnt && !gnt;
    pop[1]  = load && any_gnt && gnt;

    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    out_addr_d  = out_addr_q;
    out_id_d    = out_id_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = any_gnt;
      if (any_gnt) begin
        out_addr_d = mem_addr_q[gnt][head_q[gnt]];
        out_id_d   = mem_id_q[gnt][head_q[gnt]];
        out_lane_d = gnt;
        rr_d       = gnt ? RR_LANE1 : RR_LANE2;
      end
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (hit[n]) begin
        head_d[n] = head_q[n];
        tail_d[n] = head_q[n] + k[n][PW-1:0];
        cnt_d[n]  = k[n];
      end else begin
        head_d[n] = head_q[n] + PW'(pop[n]);
        tail_d[n] = tail_q[n] + PW'(push[n]);
        cnt_d[n]  = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
      end
    end
    inc    = 16'(out_hit[0]) + 16'(out_hit[1]) + 16'(sq[0]) + 16'(sq[1]) +
             16'(in_drop[0]) + 16'(in_drop[1]);
    total  = 17'(drop_q) + 17'(inc);
    drop_d = (total > 17'd255) ? 8'hFF : total[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < 2; n++) begin
        head_q[n] <= '0;
        tail_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_lane_q  <= 1'b0;
      out_addr_q  <= '0;
      out_id_q    <= '0;
      rr_q        <= RR_LANE1;
      drop_q      <= '0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        head_q[n] <= head_d[n];
        tail_q[n] <= tail_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_addr_q  <= out_addr_d;
      out_id_q    <= out_id_d;
      rr_q        <= rr_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_addr_q[n][tail_q[n]] <= in_addr[n];
        mem_id_q[n][tail_q[n]]   <= in_idv[n];
      end
    end
  end

  assign out_stall_1 = stall[0];
  assign out_stall_2 = stall[1];
  assign out_valid   = out_valid_q;
  assign out_lane    = out_lane_q;
  assign out_address = out_addr_q;
  assign out_id      = out_id_q;
  assign drop_count  = drop_q;

endmodule
